// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the TPU pass sequencer.
package tpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StCompute,
        StDrain,
        StDone
    } seq_state_t;

    // A skewed DIM x DIM systolic pass needs 3*DIM-2 shift/MAC cycles.
    function automatic int unsigned compute_len(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

    function automatic int unsigned row_w(input int unsigned dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/seq_row_counter.sv
// Row counter that advances on handshake beats, with a terminal-row flag.
module seq_row_counter #(
    parameter int unsigned W    = 3,
    parameter int unsigned LAST = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    localparam logic [W-1:0] LastVal = W'(LAST);

    // clr has priority so a terminal beat wraps to 0 instead of overflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign last = (cnt == LastVal);

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Pass sequencer for the memA/memB + systolic array datapath: clear, load, compute, drain.
// Define TPU_SEQ_PERF_EN to add saturating load/drain stall counters.
module tpu_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int unsigned DIM   = 8,
    parameter int unsigned CNT_W = $clog2(3 * DIM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  mem_wr_en,
    output logic [row_w(DIM)-1:0] mem_row,
    output logic                  mem_en,
    output logic                  mac_en,
    output logic                  mac_clr,
    output logic [row_w(DIM)-1:0] c_row,
    output logic                  busy,
    output logic                  done
`ifdef TPU_SEQ_PERF_EN
   ,output logic [15:0]           perf_load_stall,
    output logic [15:0]           perf_drain_stall
`endif
);

    localparam int unsigned      RowW      = row_w(DIM);
    localparam logic [CNT_W-1:0] PhaseLast = CNT_W'(compute_len(DIM) - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] phase_q;
    logic             abort_act, rd_beat, load_last, drain_last, phase_done;

    assign abort_act  = abort && (state_q != StIdle);
    assign mem_wr_en  = in_valid && in_ready;
    assign rd_beat    = out_valid && out_ready;
    assign phase_done = (phase_q == PhaseLast);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StClear;
            StClear:   state_d = StLoad;
            StLoad:    if (mem_wr_en && load_last) state_d = StCompute;
            StCompute: if (phase_done) state_d = StDrain;
            StDrain:   if (rd_beat && drain_last) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (abort_act) state_d = StIdle;
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            in_ready  <= 1'b0;
            mac_clr   <= 1'b0;
            mem_en    <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= (state_q == StCompute && state_d == StCompute) ? phase_q + CNT_W'(1)
                                                                         : '0;
            in_ready  <= (state_d == StLoad);
            mac_clr   <= (state_d == StClear);
            mem_en    <= (state_d == StCompute);
            mac_en    <= (state_d == StCompute);
            out_valid <= (state_d == StDrain);
            done      <= (state_d == StDone);
            busy      <= (state_d != StIdle);
        end
    end

    seq_row_counter #(
        .W    (RowW),
        .LAST (DIM - 1)
    ) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort_act || (mem_wr_en && load_last)),
        .inc   (mem_wr_en),
        .cnt   (mem_row),
        .last  (load_last)
    );

    seq_row_counter #(
        .W    (RowW),
        .LAST (DIM - 1)
    ) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort_act || (rd_beat && drain_last)),
        .inc   (rd_beat),
        .cnt   (c_row),
        .last  (drain_last)
    );

`ifdef TPU_SEQ_PERF_EN
    logic start_acc;
    assign start_acc = (state_q == StIdle) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_load_stall  <= '0;
            perf_drain_stall <= '0;
        end else if (start_acc) begin
            perf_load_stall  <= '0;
            perf_drain_stall <= '0;
        end else begin
            if (state_q == StLoad && !in_valid && perf_load_stall != 16'hFFFF) begin
                perf_load_stall <= perf_load_stall + 16'd1;
            end
            if (state_q == StDrain && !out_ready && perf_drain_stall != 16'hFFFF) begin
                perf_drain_stall <= perf_drain_stall + 16'd1;
            end
        end
    end
`else
    // Stall counters compiled out: no ports, no state, same sequencing.
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Self-checking bench for tpu_seq_ctrl with a row scoreboard on writes and drains.
module tb_tpu_seq_ctrl;

    localparam int unsigned DIM = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, mem_wr_en, mem_en, mac_en, mac_clr, busy, done;
    logic [2:0] mem_row, c_row;
`ifdef TPU_SEQ_PERF_EN
    logic [15:0] perf_load_stall, perf_drain_stall;
`endif

    always #5 clk = ~clk;

    tpu_seq_ctrl #(
        .DIM (DIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .mem_wr_en (mem_wr_en),
        .mem_row   (mem_row),
        .mem_en    (mem_en),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .c_row     (c_row),
        .busy      (busy),
        .done      (done)
`ifdef TPU_SEQ_PERF_EN
       ,.perf_load_stall  (perf_load_stall),
        .perf_drain_stall (perf_drain_stall)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc, clr_cyc, first_comp_cyc, last_comp_cyc, done_cyc;
    int n_clr, n_wr, n_comp, n_rd, n_done;
    logic [2:0] exp_wr[$];
    logic [2:0] exp_rd[$];
    logic [2:0] e;

    // Monitor: samples mid-cycle, pops expected rows on each handshake beat.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && !busy) start_cyc = cyc;
            if (mac_clr) begin n_clr++; clr_cyc = cyc; end
            if (mem_en) begin
                if (n_comp == 0) first_comp_cyc = cyc;
                last_comp_cyc = cyc;
                n_comp++;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            checks++;
            if ((mem_wr_en && mem_en) || (mac_clr && mac_en)) begin
                errors++;
                $display("FAIL excl: wr=%0b en=%0b clr=%0b mac=%0b, required no overlap",
                         mem_wr_en, mem_en, mac_clr, mac_en);
            end
            if (mem_wr_en) begin
                n_wr++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_row: unexpected write row=%0d", mem_row);
                end else begin
                    e = exp_wr.pop_front();
                    if (mem_row !== e) begin
                        errors++;
                        $display("FAIL wr_row: got %0d want %0d", mem_row, e);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_rd++;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_row: unexpected drain row=%0d", c_row);
                end else begin
                    e = exp_rd.pop_front();
                    if (c_row !== e) begin
                        errors++;
                        $display("FAIL rd_row: got %0d want %0d", c_row, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_clr = 0; n_wr = 0; n_comp = 0; n_rd = 0; n_done = 0;
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic push_rows(input int nw, input int nr);
        for (int i = 0; i < nw; i++) exp_wr.push_back(3'(i));
        for (int i = 0; i < nr; i++) exp_rd.push_back(3'(i));
    endtask

    task automatic run_pass(output bit ok);
        ok = 1'b0;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, in_ready, out_valid, mem_wr_en, mem_en, mac_en, mac_clr, mem_row, c_row}
            !== 14'd0) begin
            errors++;
            $display("FAIL reset_outs: got busy=%0b done=%0b rdy=%0b ov=%0b en=%0b, required all 0",
                     busy, done, in_ready, out_valid, mem_en);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b rdy=%0b ov=%0b, required 0", busy, in_ready,
                     out_valid);
        end
    endtask

    task automatic test_nominal();
        bit ok;
        clear_stats();
        push_rows(8, 8);
        run_pass(ok);
        checks++; if (!ok) begin errors++; $display("FAIL nom_timeout: no done pulse"); end
        checks++;
        if (n_clr !== 1 || clr_cyc - start_cyc !== 1) begin
            errors++;
            $display("FAIL nom_clr: got n=%0d at +%0d, want 1 at +1", n_clr, clr_cyc - start_cyc);
        end
        checks++;
        if (n_wr !== 8) begin errors++; $display("FAIL nom_wr: got %0d want 8", n_wr); end
        checks++;
        if (n_comp !== 22 || last_comp_cyc - first_comp_cyc !== 21) begin
            errors++;
            $display("FAIL nom_comp: got %0d span %0d want 22 span 21", n_comp,
                     last_comp_cyc - first_comp_cyc);
        end
        checks++;
        if (first_comp_cyc - start_cyc !== 10) begin
            errors++;
            $display("FAIL nom_comp_start: got +%0d want +10", first_comp_cyc - start_cyc);
        end
        checks++;
        if (n_rd !== 8) begin errors++; $display("FAIL nom_rd: got %0d want 8", n_rd); end
        checks++;
        if (n_done !== 1 || done_cyc - start_cyc !== 40) begin
            errors++;
            $display("FAIL nom_done: got n=%0d at +%0d want 1 at +40", n_done,
                     done_cyc - start_cyc);
        end
        checks++;
        if (exp_wr.size() + exp_rd.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL nom_end: left wr=%0d rd=%0d busy=%0b, want 0 0 0", exp_wr.size(),
                     exp_rd.size(), busy);
        end
    endtask

    task automatic test_load_gaps();
        bit seen = 1'b0;
        clear_stats();
        push_rows(8, 8);
        out_ready = 1'b1;
        for (int j = 0; j < 200; j++) begin
            start = (j == 0);
            in_valid = (j >= 2) && ((j - 2) % 3 == 0);
            tick();
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (!seen) begin errors++; $display("FAIL gap_timeout: no done pulse"); end
        checks++;
        if (n_wr !== 8) begin errors++; $display("FAIL gap_wr: got %0d want 8", n_wr); end
        checks++;
        if (first_comp_cyc - start_cyc !== 24 || n_comp !== 22) begin
            errors++;
            $display("FAIL gap_comp: got +%0d n=%0d want +24 n=22", first_comp_cyc - start_cyc,
                     n_comp);
        end
        checks++;
        if (n_done !== 1 || done_cyc - start_cyc !== 54 || exp_rd.size() !== 0) begin
            errors++;
            $display("FAIL gap_done: got n=%0d at +%0d left=%0d want 1 at +54 left 0", n_done,
                     done_cyc - start_cyc, exp_rd.size());
        end
`ifdef TPU_SEQ_PERF_EN
        checks++;
        if (perf_load_stall !== 16'd14) begin
            errors++;
            $display("FAIL gap_perf: got %0d want 14", perf_load_stall);
        end
`endif
    endtask

    task automatic test_drain_backpressure();
        bit seen = 1'b0;
        bit held = 1'b0;
        clear_stats();
        push_rows(8, 8);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            start = 1'b0;
            if (out_valid && c_row == 3'd3 && !held) begin
                held = 1'b1;
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    checks++;
                    if (c_row !== 3'd3 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_hold: got row=%0d ov=%0b want row=3 ov=1", c_row,
                                 out_valid);
                    end
                end
                out_ready = 1'b1;
            end
            if (done) begin seen = 1'b1; break; end
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL bp_timeout: no done pulse"); end
        checks++;
        if (n_rd !== 8 || exp_rd.size() !== 0) begin
            errors++;
            $display("FAIL bp_rows: got %0d left %0d want 8 left 0", n_rd, exp_rd.size());
        end
        checks++;
        if (n_done !== 1 || done_cyc - start_cyc !== 45) begin
            errors++;
            $display("FAIL bp_done: got n=%0d at +%0d want 1 at +45", n_done,
                     done_cyc - start_cyc);
        end
`ifdef TPU_SEQ_PERF_EN
        checks++;
        if (perf_drain_stall !== 16'd5) begin
            errors++;
            $display("FAIL bp_perf: got %0d want 5", perf_drain_stall);
        end
`endif
    endtask

    task automatic test_abort();
        bit ok;
        clear_stats();
        push_rows(5, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            start = (j == 0);
            abort = (j == 6);
            tick();
        end
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if ({busy, in_ready, mem_row} !== 5'd0 || n_wr !== 5 || exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b rdy=%0b row=%0d wr=%0d want 0 0 0 5", busy,
                     in_ready, mem_row, n_wr);
        end
        tick(); tick(); tick();
        checks++;
        if (n_done !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: got done=%0d busy=%0b want 0 0", n_done, busy);
        end
        clear_stats();
        push_rows(8, 8);
        run_pass(ok);
        checks++;
        if (!ok || n_wr !== 8 || n_done !== 1 || exp_wr.size() + exp_rd.size() !== 0) begin
            errors++;
            $display("FAIL abort_rerun: got ok=%0b wr=%0d done=%0d want 1 8 1", ok, n_wr,
                     n_done);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        bit seen = 1'b0;
        clear_stats();
        push_rows(8, 8);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int j = 0; j < 200; j++) begin
            start = (j == 0) || (j >= 15 && j <= 20) || (j >= 33 && j <= 36);
            tick();
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        checks++;
        if (!seen || n_done !== 1 || busy !== 1'b0 || done_cyc - start_cyc !== 40) begin
            errors++;
            $display("FAIL start_ign: got done=%0d busy=%0b at +%0d want 1 0 +40", n_done, busy,
                     done_cyc - start_cyc);
        end
        checks++;
        if (n_wr !== 8 || n_rd !== 8) begin
            errors++;
            $display("FAIL start_ign_rows: got wr=%0d rd=%0d want 8 8", n_wr, n_rd);
        end
        clear_stats();
        push_rows(8, 8);
        run_pass(ok);
        checks++;
        if (!ok || n_done !== 1) begin
            errors++;
            $display("FAIL start_next: got ok=%0b done=%0d want 1 1", ok, n_done);
        end
    endtask

    task automatic test_reset_mid_compute();
        clear_stats();
        push_rows(8, 8);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            start = (j == 0);
            tick();
        end
        start = 1'b0;
        checks++;
        if (mem_en !== 1'b1 || n_comp !== 10) begin
            errors++;
            $display("FAIL rst_mid_pre: got en=%0b n=%0d want 1 10", mem_en, n_comp);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready, out_valid, mem_wr_en, mem_en, mac_en, mac_clr, mem_row, c_row}
            !== 14'd0) begin
            errors++;
            $display("FAIL rst_mid_outs: got busy=%0b en=%0b mac=%0b, required all 0", busy,
                     mem_en, mac_en);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, in_ready, out_valid, mem_en} !== 4'd0 || n_done !== 0) begin
            errors++;
            $display("FAIL rst_mid_idle: got busy=%0b rdy=%0b done=%0d want 0 0 0", busy,
                     in_ready, n_done);
        end
        clear_stats();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_load_gaps();
        test_drain_backpressure();
        test_abort();
        test_start_ignored();
        test_reset_mid_compute();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
- Sequences one DIM x DIM matrix-multiply pass through the operand memories and the tpumac systolic array.
- Pass order: clear the accumulators, accept DIM operand rows over a valid/ready handshake, then enable the skewed shift/MAC phase for exactly 3*DIM-2 cycles, then stream DIM result rows out.
- Sits between the host/loader interface and the memA/memB/systolic-array datapath, and owns every enable and write-enable those blocks see.

Parameters:
- DIM, 8, array dimension; number of operand rows and result rows per pass.
- CNT_W, $clog2(3*DIM), width of the internal phase counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a pass; sampled only in IDLE
- abort  input  1  synchronous cancel; honoured in any non-IDLE state
- in_valid  input  1  operand row presented by loader
- in_ready  output  1  controller accepts operand row this cycle
- out_ready  input  1  consumer accepts result row
- out_valid  output  1  result row presented
- mem_wr_en  output  1  write strobe to memA/memB (an accepted in_valid/in_ready beat)
- mem_row  output  $clog2(DIM)  row index for the current operand write
- mem_en  output  1  shift enable to memA/memB
- mac_en  output  1  MAC enable to the systolic array
- mac_clr  output  1  accumulator clear
- c_row  output  $clog2(DIM)  result row select
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a pass completes

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - State = IDLE and all counters = 0.
  - Every output = 0, including in_ready, out_valid, done and busy.
- States: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - start is ignored in any other state.
- CLEAR:
  - Lasts exactly 1 cycle with mac_clr=1, then -> LOAD.
- LOAD:
  - in_ready=1.
  - Each beat with in_valid&in_ready asserts mem_wr_en combinationally, with mem_row = row counter, and the counter increments.
  - Beat with mem_row=DIM-1 -> COMPUTE; counter is cleared.
  - No beat -> counter holds.
  - in_ready=0 in all other states.
- COMPUTE:
  - mem_en=1 and mac_en=1 for exactly 3*DIM-2 consecutive cycles (22 at DIM=8), then -> DRAIN.
  - No stall input exists; COMPUTE cannot be paused.
- DRAIN:
  - out_valid=1 and c_row = row counter.
  - On out_valid&out_ready the counter increments.
  - c_row must stay stable while out_ready=0.
  - Beat at c_row=DIM-1 -> DONE.
- DONE:
  - done=1 for 1 cycle, then -> IDLE.
  - busy deasserts in the IDLE cycle.
- abort:
  - Any non-IDLE state -> IDLE on the next edge; counters are cleared.
  - Every strobe is 0 from that edge on.
  - done is not pulsed.
  - abort wins over a simultaneous handshake beat: mem_wr_en is still asserted combinationally that cycle, but the counter is discarded.
- Counters:
  - Row counter wraps to 0 only through the state transition, never by overflow.
  - Phase counter compares against 3*DIM-3 (terminal value).
- Mutual exclusion: mem_wr_en and mem_en are never both 1; mac_clr is never 1 with mac_en.

Optional Feature:
- Macro TPU_SEQ_PERF_EN.
- When defined, adds these outputs:
  - perf_load_stall (16b): counts LOAD cycles with in_valid=0.
  - perf_drain_stall (16b): counts DRAIN cycles with out_ready=0.
- Counter rules:
  - Both counters clear on start and saturate at 16'hFFFF.
  - Values hold after DONE until the next start.
  - Reset clears both.
- When undefined: ports and logic are absent and the timing is identical.

Decomposition:
- Package tpu_pkg:
  - state enum typedef seq_state_t.
  - localparam-style functions for compute length (3*DIM-2) and row index width.
- One natural sub-module: seq_row_counter.
  - Load/clear/increment-on-beat counter with terminal flag.
  - Instantiated twice: LOAD rows and DRAIN rows.
- The COMPUTE phase counter stays inline.

Test Plan:
- Reset mid-COMPUTE: assert rst_n=0 at compute cycle 10 -> all outputs 0 immediately; IDLE after release; busy=0.
- Nominal DIM=8 pass with in_valid and out_ready held high:
  - mac_clr at cycle 1.
  - 8 mem_wr_en beats with mem_row 0..7.
  - Exactly 22 mem_en/mac_en cycles.
  - 8 out_valid beats with c_row 0..7.
  - done pulse; total 1+1+8+22+8+1 cycles from start.
- Loader gaps: in_valid toggles 1,0,0,1,... -> mem_row advances only on beats; exactly 8 writes; COMPUTE entry delayed by the gap count (perf_load_stall equals the gap count when TPU_SEQ_PERF_EN is defined).
- Drain backpressure: out_ready=0 for 5 cycles at c_row=3 -> c_row holds 3, out_valid stays 1; no skipped or duplicated rows.
- Abort during LOAD after 4 beats, coincident with a beat -> IDLE next cycle, no done pulse. A following start runs a full pass with mem_row restarting at 0.
- start asserted during COMPUTE and DRAIN -> ignored; only one done pulse; a subsequent start in IDLE begins a new pass.
